// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared encodings for the UART transmit frame generator
//
// Purpose: state encoding, parity-type and line-level constants used by
//          uart_tx_frame_gen and uart_parity_calc.
// Ports:   none (package).

package uart_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// rtl/uart_parity_calc.sv - combinational even/odd parity of a data word
//
// Purpose: produces the parity bit inserted after the data bits of a frame.
// Ports:
//   data    [DATA_WIDTH-1:0] in  word to protect (the latched frame data)
//   par_typ                  in  PAR_EVEN (0) or PAR_ODD (1)
//   par_bit                  out bit that makes the total count of ones
//                                even (PAR_EVEN) or odd (PAR_ODD)

module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame_gen.sv
// rtl/uart_tx_frame_gen.sv - self-sequencing UART transmit frame serializer
//
// Purpose: accepts a parallel word and sends start bit, LSB-first data,
//          optional parity and 1 or 2 stop bits, each held CLKS_PER_BIT clocks.
// Ports:
//   clk                       in  rising-edge clock
//   RST                       in  asynchronous active-low reset
//   P_DATA [DATA_WIDTH-1:0]   in  word to send, sampled on accept
//   Data_Valid                in  send request, accepted in IDLE or last stop clock
//   PAR_EN                    in  insert parity bit, sampled on accept
//   PAR_TYP                   in  0 even / 1 odd parity, sampled on accept
//   STOP2                     in  two stop bits when 1, sampled on accept
//   TX_OUT                    out registered serial line, idle high
//   busy                      out high while a frame is on the line

module uart_tx_frame_gen
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    tx_state_t             w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [IDX_W-1:0]      w_idx_inc;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_stop2;
    logic                  r_tx;
    logic                  r_busy;
    logic                  w_tx_nxt;
    logic                  w_busy_nxt;
    logic                  w_par_bit;
    logic                  w_bit_end;
    logic [IDX_W-1:0]      w_stop_last_idx;
    logic                  w_frame_end;
    logic                  w_accept;
    logic                  w_next_data_bit;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (r_data),
        .par_typ (r_par_typ),
        .par_bit (w_par_bit)
    );

    assign w_bit_end       = (r_cnt == CNT_LAST);
    assign w_idx_inc       = r_idx + IDX_W'(1);
    // The stop-bit index runs 0..STOP2, so its last value is the latched STOP2 itself.
    assign w_stop_last_idx = {{(IDX_W-1){1'b0}}, r_stop2};
    assign w_frame_end     = (r_state == STOP) && w_bit_end && (r_idx == w_stop_last_idx);
    // The final clock of the last stop bit also accepts, giving gap-free back-to-back frames.
    assign w_accept        = Data_Valid && ((r_state == IDLE) || w_frame_end);

    // Data bit that goes on the line when the bit index advances.
    always_comb begin
        w_next_data_bit = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (w_idx_inc == IDX_W'(i)) begin
                w_next_data_bit = r_data[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;

        if (w_accept) begin
            w_state_nxt = START;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_tx_nxt    = START_BIT;
            w_busy_nxt  = 1'b1;
        end else if (r_state != IDLE) begin
            if (!w_bit_end) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end else begin
                w_cnt_nxt = '0;
                case (r_state)
                    START: begin
                        w_state_nxt = DATA;
                        w_idx_nxt   = '0;
                        w_tx_nxt    = r_data[0];
                    end
                    DATA: begin
                        if (r_idx == IDX_LAST) begin
                            w_idx_nxt = '0;
                            if (r_par_en) begin
                                w_state_nxt = PARITY;
                                w_tx_nxt    = w_par_bit;
                            end else begin
                                w_state_nxt = STOP;
                                w_tx_nxt    = STOP_BIT;
                            end
                        end else begin
                            w_idx_nxt = w_idx_inc;
                            w_tx_nxt  = w_next_data_bit;
                        end
                    end
                    PARITY: begin
                        w_state_nxt = STOP;
                        w_idx_nxt   = '0;
                        w_tx_nxt    = STOP_BIT;
                    end
                    STOP: begin
                        if (r_idx == w_stop_last_idx) begin
                            w_state_nxt = IDLE;
                            w_idx_nxt   = '0;
                            w_tx_nxt    = STOP_BIT;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_idx_nxt = w_idx_inc;
                        end
                    end
                    default: begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = '0;
                        w_tx_nxt    = STOP_BIT;
                        w_busy_nxt  = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_tx      <= STOP_BIT;
            r_busy    <= 1'b0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= PAR_EVEN;
            r_stop2   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            if (w_accept) begin
                r_data    <= P_DATA;
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
                r_stop2   <= STOP2;
            end
        end
    end

    assign TX_OUT = r_tx;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// tb/tb_uart_tx_frame_gen.sv - self-checking bench for uart_tx_frame_gen

module tb_uart_tx_frame_gen;

    logic       clk = 1'b0;
    logic       RST;
    logic [7:0] d1, d4;
    logic       dv1, dv4, pe1, pe4, pt1, pt4, s21, s24;
    logic       tx1, tx4, bz1, bz4;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Expected line schedule: one entry per clock still to be driven by the frame(s)
    // already accepted; empty means idle.
    bit q1[$];
    bit q4[$];

    always #5 clk = ~clk;

    uart_tx_frame_gen #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .RST(RST), .P_DATA(d1), .Data_Valid(dv1), .PAR_EN(pe1),
        .PAR_TYP(pt1), .STOP2(s21), .TX_OUT(tx1), .busy(bz1)
    );

    uart_tx_frame_gen #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .RST(RST), .P_DATA(d4), .Data_Valid(dv4), .PAR_EN(pe4),
        .PAR_TYP(pt4), .STOP2(s24), .TX_OUT(tx4), .busy(bz4)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic frame_bits(input logic [7:0] d, input logic pe, input logic pt,
                              input logic s2, output logic [12:0] bits, output int n);
        int ones;
        ones = $countones(d);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        n = 9;
        if (pe) begin
            bits[n] = ((ones + (pt ? 1 : 0)) % 2) != 0;
            n++;
        end
        bits[n] = 1'b1;
        n++;
        if (s2) begin
            bits[n] = 1'b1;
            n++;
        end
    endtask

    always @(posedge clk or negedge RST) begin
        logic [12:0] b;
        int          n;
        bit          acc;
        if (!RST) begin
            q1.delete();
            q4.delete();
        end else begin
            acc = dv1 && (q1.size() <= 1);
            if (q1.size() != 0) void'(q1.pop_front());
            if (acc) begin
                frame_bits(d1, pe1, pt1, s21, b, n);
                for (int i = 0; i < n; i++) q1.push_back(b[i]);
            end
            acc = dv4 && (q4.size() <= 1);
            if (q4.size() != 0) void'(q4.pop_front());
            if (acc) begin
                frame_bits(d4, pe4, pt4, s24, b, n);
                for (int i = 0; i < n; i++) repeat (4) q4.push_back(b[i]);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && RST) begin
            check_eq("mon_tx1",   tx1, (q1.size() != 0) ? q1[0] : 1'b1);
            check_eq("mon_busy1", bz1, q1.size() != 0);
            check_eq("mon_tx4",   tx4, (q4.size() != 0) ? q4[0] : 1'b1);
            check_eq("mon_busy4", bz4, q4.size() != 0);
        end
    end

    task automatic pulse1(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
        d1 = d; pe1 = pe; pt1 = pt; s21 = s2; dv1 = 1'b1;
        @(negedge clk);
        dv1 = 1'b0;
    endtask

    task automatic pulse4(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
        d4 = d; pe4 = pe; pt4 = pt; s24 = s2; dv4 = 1'b1;
        @(negedge clk);
        dv4 = 1'b0;
    endtask

    task automatic capture(input bit sel, input int n, output logic [63:0] v, output int bc);
        v  = '0;
        bc = 0;
        for (int i = 0; i < n; i++) begin
            v[i] = sel ? tx4 : tx1;
            bc  += (sel ? bz4 : bz1) ? 1 : 0;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [63:0] v;
        logic [10:0] s;
        int          bc;
        bit          allb;

        RST = 1'b1;
        dv1 = 0; dv4 = 0; d1 = 0; d4 = 0;
        pe1 = 0; pe4 = 0; pt1 = 0; pt4 = 0; s21 = 0; s24 = 0;
        #1 RST = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx1", tx1, 1'b1);
        check_eq("rst_busy1", bz1, 1'b0);
        check_eq("rst_tx4", tx4, 1'b1);
        check_eq("rst_busy4", bz4, 1'b0);
        RST = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        pulse1(8'hA5, 1'b1, 1'b0, 1'b0);
        capture(1'b0, 11, v, bc);
        check_eq("t1_seq", v[10:0], 11'b10101001010);
        check_eq("t1_busy_len", bc, 11);
        check_eq("t1_idle_tx", tx1, 1'b1);
        check_eq("t1_idle_busy", bz1, 1'b0);

        pulse1(8'h01, 1'b1, 1'b1, 1'b1);
        capture(1'b0, 12, v, bc);
        check_eq("t2_seq", v[11:0], 12'b110000000010);
        check_eq("t2_busy_len", bc, 12);
        check_eq("t2_idle_busy", bz1, 1'b0);

        pulse1(8'h3C, 1'b0, 1'b0, 1'b0);
        allb = 1'b1;
        v = '0;
        for (int i = 0; i < 20; i++) begin
            if (i == 9) begin d1 = 8'hC3; dv1 = 1'b1; end
            if (i == 10) dv1 = 1'b0;
            allb &= bz1;
            v[i] = tx1;
            @(negedge clk);
        end
        check_eq("t3_busy_held", allb, 1'b1);
        check_eq("t3_second_start", v[10], 1'b0);
        check_eq("t3_seq", v[19:0], 20'hE1A78);
        check_eq("t3_idle_busy", bz1, 1'b0);

        pulse1(8'h00, 1'b0, 1'b0, 1'b0);
        v = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin d1 = 8'hFF; dv1 = 1'b1; end
            if (i == 4) dv1 = 1'b0;
            v[i] = tx1;
            @(negedge clk);
        end
        check_eq("t4_seq", v[9:0], 10'h200);
        repeat (3) @(negedge clk);
        check_eq("t4_idle_tx", tx1, 1'b1);
        check_eq("t4_idle_busy", bz1, 1'b0);

        pulse4(8'h55, 1'b0, 1'b0, 1'b1);
        capture(1'b1, 44, v, bc);
        for (int k = 0; k < 11; k++) s[k] = v[4*k+1];
        check_eq("t5_mid_bit_samples", s, 11'b11010101010);
        check_eq("t5_busy_len", bc, 44);
        check_eq("t5_idle_tx", tx4, 1'b1);
        check_eq("t5_idle_busy", bz4, 1'b0);

        for (int c = 0; c < 800; c++) begin
            dv1 = ($urandom_range(0, 5) == 0);
            d1  = 8'($urandom);
            pe1 = 1'($urandom); pt1 = 1'($urandom); s21 = 1'($urandom);
            dv4 = ($urandom_range(0, 9) == 0);
            d4  = 8'($urandom);
            pe4 = 1'($urandom); pt4 = 1'($urandom); s24 = 1'($urandom);
            @(negedge clk);
        end
        dv1 = 1'b0;
        dv4 = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("rand_idle_busy1", bz1, 1'b0);
        check_eq("rand_idle_busy4", bz4, 1'b0);

        pulse1(8'hF0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("t6_bit3_on_line", tx1, 1'b0);
        #2 RST = 1'b0;
        #1;
        check_eq("t6_async_tx", tx1, 1'b1);
        check_eq("t6_async_busy", bz1, 1'b0);
        repeat (2) @(negedge clk);
        RST = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("t6_idle_tx", tx1, 1'b1);
        check_eq("t6_idle_busy", bz1, 1'b0);
        pulse1(8'h5A, 1'b1, 1'b0, 1'b0);
        capture(1'b0, 11, v, bc);
        check_eq("t6_fresh_seq", v[10:0], 11'b10010110100);
        check_eq("t6_fresh_busy_len", bc, 11);
        check_eq("t6_fresh_idle", bz1, 1'b0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
